// File: rtl/dump_pkg.sv
// dump_pkg: shared types and constants for the register-file dump engine.
//   state_t  : dump FSM states
//   MISSED_W : width of the saturating dropped-trigger counter
package dump_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        CAPTURE,
        SEND,
        DONE
    } state_t;

    localparam int MISSED_W = 8;

endpackage

// File: rtl/dump_period_timer.sv
// dump_period_timer: free-running auto-trigger timer for the dump engine.
//   clk, rst : clock, asynchronous active-high reset
//   en       : enable counting
//   period   : tick interval in cycles; 0 stops and clears the timer
//   tick     : one-cycle pulse every period cycles while running
module dump_period_timer #(
    parameter int PER_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [PER_W-1:0] period,
    output logic             tick
);

    logic [PER_W-1:0] cnt;
    logic             run;

    assign run = en && (period != '0);
    // >= rather than == so that shrinking period below the running count
    // wraps at once instead of counting through the whole range.
    assign tick = run && (cnt >= period - 1'b1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (!run || tick)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/reg_dump_ctrl.sv
// reg_dump_ctrl: streams every register of a register file over valid/ready.
//   clk, rst         : clock, asynchronous active-high reset
//   start            : one-cycle dump request
//   auto_en, period  : periodic auto-trigger control (period 0 disables)
//   rf_raddr/rf_rdata: register-file read port, data one cycle after address
//   out_valid/ready  : handshake to the trace sink
//   out_idx/out_data : index and value of the current word
//   out_eol/out_last : end of group line / final word of the dump
//   busy, done       : dump in progress / one-cycle completion pulse
//   missed           : saturating count of auto ticks dropped while busy
module reg_dump_ctrl
    import dump_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int NREGS   = 32,
    parameter int ADDR_W  = 5,
    parameter int GROUP   = 8,
    parameter int ZERO_R0 = 1,
    parameter int PER_W   = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                auto_en,
    input  logic [PER_W-1:0]    period,
    output logic [ADDR_W-1:0]   rf_raddr,
    input  logic [DATA_W-1:0]   rf_rdata,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ADDR_W-1:0]   out_idx,
    output logic [DATA_W-1:0]   out_data,
    output logic                out_eol,
    output logic                out_last,
    output logic                busy,
    output logic                done,
    output logic [MISSED_W-1:0] missed
);

    state_t            state;
    logic [ADDR_W-1:0] idx;
    logic              tick;
    logic              is_last;
    logic              is_eol;

    dump_period_timer #(.PER_W(PER_W)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .en     (auto_en),
        .period (period),
        .tick   (tick)
    );

    assign is_last = (idx == ADDR_W'(NREGS - 1));
    assign is_eol  = ((int'(idx) % GROUP) == GROUP - 1) || is_last;

    // rf_raddr is loaded on entry to ISSUE so a synchronous register file
    // presents the data during CAPTURE. Outputs change only on edges, so
    // out_valid has no combinational dependence on out_ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            rf_raddr  <= '0;
            out_valid <= 1'b0;
            out_idx   <= '0;
            out_data  <= '0;
            out_eol   <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            missed    <= '0;
        end else begin
            // Any tick outside IDLE (DONE included) is dropped and counted.
            if (tick && state != IDLE && missed != '1)
                missed <= missed + 1'b1;
            case (state)
                IDLE: begin
                    if (start || tick) begin
                        idx      <= '0;
                        rf_raddr <= '0;
                        busy     <= 1'b1;
                        state    <= ISSUE;
                    end
                end
                ISSUE: state <= CAPTURE;
                CAPTURE: begin
                    out_data  <= (ZERO_R0 != 0 && idx == '0) ? '0 : rf_rdata;
                    out_idx   <= idx;
                    out_eol   <= is_eol;
                    out_last  <= is_last;
                    out_valid <= 1'b1;
                    state     <= SEND;
                end
                SEND: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (is_last) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            idx      <= idx + 1'b1;
                            rf_raddr <= idx + 1'b1;
                            state    <= ISSUE;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_dump_ctrl.sv
// tb_reg_dump_ctrl: directed self-checking bench for reg_dump_ctrl.
module tb_reg_dump_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, auto_en, ready;
    logic [15:0] period;
    logic [4:0]  raddr, oidx;
    logic [31:0] rdata, odata;
    logic        valid, eol, last, busy, done;
    logic [7:0]  missed;

    logic        start2, ready2, auto_en2;
    logic [15:0] period2;
    logic [3:0]  raddr2, oidx2;
    logic [63:0] rdata2, odata2;
    logic        valid2, eol2, last2, busy2, done2;
    logic [7:0]  missed2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reg_dump_ctrl u_dut (
        .clk(clk), .rst(rst), .start(start), .auto_en(auto_en), .period(period),
        .rf_raddr(raddr), .rf_rdata(rdata), .out_valid(valid), .out_ready(ready),
        .out_idx(oidx), .out_data(odata), .out_eol(eol), .out_last(last),
        .busy(busy), .done(done), .missed(missed)
    );

    reg_dump_ctrl #(.DATA_W(64), .NREGS(16), .ADDR_W(4), .GROUP(4)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .auto_en(auto_en2), .period(period2),
        .rf_raddr(raddr2), .rf_rdata(rdata2), .out_valid(valid2), .out_ready(ready2),
        .out_idx(oidx2), .out_data(odata2), .out_eol(eol2), .out_last(last2),
        .busy(busy2), .done(done2), .missed(missed2)
    );

    // Synchronous register-file models: data one cycle after the address.
    always @(posedge clk) rdata  <= 32'(raddr) * 32'h11111111;
    always @(posedge clk) rdata2 <= {32'hA5A50000 | 32'(raddr2), 32'(raddr2) * 32'h11111111};

    typedef struct {logic [4:0] idx; logic [31:0] data; logic eol; logic last;} vec_t;
    typedef struct {logic [3:0] idx; logic [63:0] data; logic eol; logic last;} vec2_t;
    vec_t  q[$];
    vec2_t q2[$];
    vec_t  tbl[32];
    vec2_t tbl2[16];

    // Inputs change just after posedge, so a word seen valid&&ready at the
    // negedge is accepted on the next posedge.
    always @(negedge clk) begin
        if (!rst && valid && ready)
            q.push_back('{oidx, odata, eol, last});
        if (!rst && valid2 && ready2)
            q2.push_back('{oidx2, odata2, eol2, last2});
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        step(1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int lim);
        int n;
        n = 0;
        while (!done && n < lim) begin
            step(1);
            n++;
        end
        chk(name, done, 1'b1);
    endtask

    task automatic wait_idle(input int lim);
        int n;
        n = 0;
        while (busy && n < lim) begin
            step(1);
            n++;
        end
        chk("idle_reached", busy, 1'b0);
    endtask

    initial begin
        int k, nd, dn;
        int t[3];
        for (int i = 0; i < 32; i++) begin
            tbl[i].idx  = 5'(i);
            tbl[i].data = (i == 0) ? 32'h0 : 32'(i) * 32'h11111111;
            tbl[i].eol  = (i == 7 || i == 15 || i == 23 || i == 31);
            tbl[i].last = (i == 31);
        end
        for (int i = 0; i < 16; i++) begin
            tbl2[i].idx  = 4'(i);
            tbl2[i].data = (i == 0) ? 64'h0 : {32'hA5A50000 | 32'(i), 32'(i) * 32'h11111111};
            tbl2[i].eol  = (i == 3 || i == 7 || i == 11 || i == 15);
            tbl2[i].last = (i == 15);
        end

        rst = 1'b1; start = 0; auto_en = 0; period = 0; ready = 1;
        start2 = 0; auto_en2 = 0; period2 = 0; ready2 = 1;
        step(3);
        chk("rst_raddr", raddr, 0);
        chk("rst_valid", valid, 0);
        chk("rst_idx", oidx, 0);
        chk("rst_data", odata, 0);
        chk("rst_eol", eol, 0);
        chk("rst_last", last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_missed", missed, 0);
        rst = 1'b0;
        step(2);

        // Full dump, sink always ready; done seen 97 edges after start.
        q.delete();
        pulse_start();
        chk("busy_after_start", busy, 1);
        k = 1;
        while (!done && k < 200) begin
            step(1);
            k++;
        end
        chk("done_cycle", k, 97);
        step(1);
        chk("done_one_cycle", done, 0);
        chk("busy_cleared", busy, 0);
        chk("word_count", q.size(), 32);
        for (int i = 0; i < 32 && i < q.size(); i++) begin
            chk($sformatf("w%0d_idx", i), q[i].idx, tbl[i].idx);
            chk($sformatf("w%0d_data", i), q[i].data, tbl[i].data);
            chk($sformatf("w%0d_eol", i), q[i].eol, tbl[i].eol);
            chk($sformatf("w%0d_last", i), q[i].last, tbl[i].last);
        end

        // Stalled sink at index 5.
        step(3);
        q.delete();
        pulse_start();
        k = 0;
        while (raddr != 5'd5 && k < 100) begin
            step(1);
            k++;
        end
        ready = 1'b0;
        k = 0;
        while (!valid && k < 10) begin
            step(1);
            k++;
        end
        chk("stall_valid_seen", valid, 1);
        for (int c = 0; c < 10; c++) begin
            chk("stall_valid", valid, 1);
            chk("stall_idx", oidx, 5);
            chk("stall_data", odata, 32'h55555555);
            step(1);
        end
        ready = 1'b1;
        wait_done("stall_done", 200);
        step(1);
        chk("stall_count", q.size(), 32);
        for (int i = 0; i < 32 && i < q.size(); i++) begin
            chk($sformatf("s%0d_idx", i), q[i].idx, tbl[i].idx);
            chk($sformatf("s%0d_data", i), q[i].data, tbl[i].data);
        end

        // Auto mode, period 200: dumps 200 cycles apart, nothing missed.
        do_reset();
        q.delete();
        period = 16'd200;
        auto_en = 1'b1;
        nd = 0;
        k = 0;
        while (nd < 3 && k < 1000) begin
            step(1);
            k++;
            if (done) begin
                t[nd] = k;
                nd++;
            end
        end
        chk("auto200_dumps", nd, 3);
        chk("auto200_gap1", t[1] - t[0], 200);
        chk("auto200_gap2", t[2] - t[1], 200);
        chk("auto200_missed", missed, 0);
        chk("auto200_words", q.size(), 96);
        auto_en = 1'b0;
        wait_idle(200);

        // Auto mode, period 50: one tick lands inside each dump.
        do_reset();
        period = 16'd50;
        auto_en = 1'b1;
        wait_done("auto50_done1", 300);
        chk("auto50_missed1", missed, 1);
        step(1);
        wait_done("auto50_done2", 300);
        chk("auto50_missed2", missed, 2);
        auto_en = 1'b0;
        step(1);
        wait_idle(200);

        // Saturation of missed with a stalled sink.
        do_reset();
        ready = 1'b0;
        period = 16'd2;
        auto_en = 1'b1;
        step(1000);
        chk("sat_missed", missed, 255);
        chk("sat_valid", valid, 1);
        step(20);
        chk("sat_hold", missed, 255);
        auto_en = 1'b0;
        ready = 1'b1;

        // Reset mid-dump at index 12.
        do_reset();
        pulse_start();
        k = 0;
        while (raddr != 5'd12 && k < 100) begin
            step(1);
            k++;
        end
        ready = 1'b0;
        k = 0;
        while (!valid && k < 10) begin
            step(1);
            k++;
        end
        chk("mid_idx", oidx, 12);
        period = 16'd3;
        auto_en = 1'b1;
        step(10);
        chk("mid_missed_nonzero", missed != 0, 1);
        rst = 1'b1;
        #2;
        chk("mid_rst_valid", valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_missed", missed, 0);
        chk("mid_rst_done", done, 0);
        auto_en = 1'b0;
        ready = 1'b1;
        step(1);
        rst = 1'b0;
        dn = 0;
        for (int c = 0; c < 5; c++) begin
            step(1);
            if (done) dn++;
        end
        chk("mid_no_done", dn, 0);
        q.delete();
        pulse_start();
        k = 0;
        while (!valid && k < 10) begin
            step(1);
            k++;
        end
        chk("restart_idx", oidx, 0);
        chk("restart_data", odata, 0);
        wait_done("restart_done", 200);
        step(1);
        chk("restart_count", q.size(), 32);

        // Parameter sweep instance: 16 x 64-bit, groups of 4.
        q2.delete();
        start2 = 1'b1;
        step(1);
        start2 = 1'b0;
        k = 0;
        while (!done2 && k < 200) begin
            step(1);
            k++;
        end
        chk("p2_done", done2, 1);
        chk("p2_done_cycle", k + 1, 49);
        step(1);
        chk("p2_count", q2.size(), 16);
        for (int i = 0; i < 16 && i < q2.size(); i++) begin
            chk($sformatf("p%0d_idx", i), q2[i].idx, tbl2[i].idx);
            chk($sformatf("p%0d_data", i), q2[i].data, tbl2[i].data);
            chk($sformatf("p%0d_eol", i), q2[i].eol, tbl2[i].eol);
            chk($sformatf("p%0d_last", i), q2[i].last, tbl2[i].last);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/reg_dump_ctrl.md
Name: reg_dump_ctrl

Overview:
- Synthesizable, parametrised register-file dump engine for the mips core; replaces bench-only register printing.
- On a start pulse or a periodic auto-trigger, reads every architectural register through a dedicated read port, in index order.
- Streams each (index, value) pair out over a valid/ready interface to a trace sink (UART bridge or bench monitor).
- Generalises the fixed 32×32-bit, 8-per-line dump to any register count, data width and group size.

Parameters:
DATA_W, 32, register data width
NREGS, 32, number of registers dumped (indices 0..NREGS-1)
ADDR_W, 5, register index width; must satisfy 2**ADDR_W >= NREGS
GROUP, 8, registers per output line; out_eol marks the last register of each group
ZERO_R0, 1, when 1 index 0 is reported as 0 regardless of rf_rdata
PER_W, 16, width of auto-trigger period

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle dump request
auto_en  in  1  enable periodic dumping
period  in  PER_W  auto-trigger interval in cycles; 0 disables auto
rf_raddr  out  ADDR_W  register-file read address
rf_rdata  in  DATA_W  read data, valid exactly 1 cycle after rf_raddr is driven
out_valid  out  1  output word valid
out_ready  in  1  sink accepts the word
out_idx  out  ADDR_W  register index of the current word
out_data  out  DATA_W  register value
out_eol  out  1  last word of a group, or the final word of the dump
out_last  out  1  final word of the dump (index NREGS-1)
busy  out  1  dump in progress
done  out  1  one-cycle pulse after the final handshake
missed  out  8  saturating count of auto-triggers dropped while busy

Behaviour:
- Reset values: rf_raddr=0, out_valid=0, out_idx=0, out_data=0, out_eol=0, out_last=0, busy=0, done=0, missed=0. State is IDLE and the period counter is 0.
- FSM states: IDLE, ISSUE, CAPTURE, SEND, DONE.
- IDLE: a trigger (start, or an auto tick) sets idx=0, moves to ISSUE and sets busy=1.
- ISSUE: drives rf_raddr=idx, then moves to CAPTURE.
- CAPTURE: registers rf_rdata into out_data (or forces 0 if ZERO_R0 and idx==0). Sets out_idx, out_eol and out_last, asserts out_valid, and moves to SEND.
- SEND: holds out_valid and all out_* stable until out_valid&&out_ready.
  - On handshake with idx==NREGS-1: out_valid drops and the FSM moves to DONE.
  - Otherwise: idx increments, out_valid drops and the FSM moves to ISSUE.
- DONE: asserts done for exactly one cycle, clears busy, and returns to IDLE. A trigger arriving in DONE is handled as if busy.
- Rate: minimum 3 cycles per word with out_ready held high. A full default dump takes 96 cycles plus 1 DONE cycle.
- out_eol = ((idx % GROUP)==GROUP-1) || idx==NREGS-1. out_last = idx==NREGS-1.
- Auto timer:
  - Counts only while auto_en && period!=0.
  - When the count reaches period-1 it wraps to 0 and emits a one-cycle tick.
  - Deasserting auto_en or setting period=0 clears the count.
- Simultaneous start and tick in IDLE produce one dump, not two.
- start while busy is ignored and not counted.
- A tick while busy (SEND waiting on a stalled sink included) increments missed, saturating at 255. The tick is dropped, not queued.
- Async reset mid-dump returns to IDLE immediately and clears out_valid and all counters. No done pulse is generated.
- No combinational path exists from out_ready to out_valid.

Decomposition:
- Package dump_pkg holds the state enum (IDLE, ISSUE, CAPTURE, SEND, DONE) and the MISSED_W=8 constant.
- One sub-module, dump_period_timer (PER_W), holds the auto counter and tick generation.
- The FSM, index counter and output registers stay in reg_dump_ctrl.

Test Plan:
- Model rf with regs[i]=i*0x11111111, hold out_ready=1, pulse start. Required response:
  - 32 words are emitted with idx 0..31.
  - Word 0 carries 0 because ZERO_R0=1.
  - out_eol is asserted at idx 7, 15, 23 and 31; out_last only at 31.
  - done pulses exactly at cycle 97 after start.
- Stalled sink: out_ready=0 for 10 cycles at idx 5 -> out_valid stays 1, and out_idx=5 and out_data=0x55555555 stay stable. The dump resumes after ready returns; no word is lost or duplicated.
- Auto mode: period=200, auto_en=1, out_ready=1 -> a dump starts every 200 cycles and missed stays 0. With period=50 -> missed increments once per tick landing during a dump.
- Saturation: period=2 with out_ready=0 held for 1000 cycles -> missed reaches 255 and stays there.
- Reset mid-dump: assert rst during SEND at idx 12 -> next cycle out_valid=0, busy=0, missed=0, no done pulse. A fresh start afterwards begins at idx 0.
- Parameter sweep NREGS=16, GROUP=4, DATA_W=64 -> 16 words, out_eol at idx 3, 7, 11 and 15, and 64-bit values intact.
